// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
package imem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam logic [31:0] IMEM_BASE = 32'h8000_0000;
    localparam logic [31:0] NOP_WORD  = 32'h0000_0013;

endpackage

// File: rtl/imem_responder_if.sv
// Fetch request/response handshake between the core (master) and the responder (slave).
interface imem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_err;

    modport master (
        output req_valid, req_addr, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_err
    );

    modport slave (
        input  req_valid, req_addr, resp_ready,
        output req_ready, resp_valid, resp_data, resp_err
    );

endinterface

// File: rtl/imem_array.sv
// Word storage: synchronous write port, combinational read port, contents not reset.
module imem_array #(
    parameter int  DEPTH = 1024,
    parameter int  WIDTH = 32,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/imem_responder.sv
// Instruction-fetch responder: one outstanding request, response after LATENCY wait cycles.
// Optional fetch-fault reporting is enabled by defining IMEM_ERR_EN.
module imem_responder
    import imem_pkg::*;
#(
    parameter int          DEPTH   = 1024,
    parameter logic [31:0] BASE    = IMEM_BASE,
    parameter int          LATENCY = 1,
    localparam int         IDX_W   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    imem_responder_if.slave  bus,
    input  logic             ld_en,
    input  logic [IDX_W-1:0] ld_idx,
    input  logic [31:0]      ld_data,
    output logic             busy
);

    localparam logic [3:0] LAT = 4'(LATENCY);

    state_t           state, state_nx;
    logic [3:0]       cnt, cnt_nx;
    logic [31:0]      data_q, data_nx;
    logic             err_q, err_nx;
    logic [IDX_W-1:0] rd_idx;
    logic [31:0]      rd_word;
    logic             addr_err;

    // Modulo-2^32 offset from BASE, word index truncated to the array size
    assign rd_idx = IDX_W'((bus.req_addr - BASE) >> 2);

`ifdef IMEM_ERR_EN
    localparam logic [32:0] SPAN = 33'(DEPTH) << 2;
    logic [31:0] offset;
    assign offset   = bus.req_addr - BASE;
    assign addr_err = (bus.req_addr[1:0] != 2'b00) || ({1'b0, offset} >= SPAN);
`else
    assign addr_err = 1'b0;
`endif

    imem_array #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_array (
        .clk   (clk),
        .we    (ld_en),
        .waddr (ld_idx),
        .wdata (ld_data),
        .raddr (rd_idx),
        .rdata (rd_word)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            data_q <= 32'd0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            data_q <= data_nx;
            err_q  <= err_nx;
        end
    end

    // The response buffer is captured at acceptance, so a same-edge load sees the old word
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        data_nx  = data_q;
        err_nx   = err_q;
        unique case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    data_nx = addr_err ? 32'd0 : rd_word;
                    err_nx  = addr_err;
                    if (LAT == 4'd0) begin
                        state_nx = RESP;
                        cnt_nx   = 4'd0;
                    end else begin
                        state_nx = WAIT;
                        cnt_nx   = LAT;
                    end
                end
            end
            WAIT: begin
                cnt_nx = cnt - 4'd1;
                if (cnt <= 4'd1) begin
                    state_nx = RESP;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.req_ready  = (state == IDLE);
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_data  = data_q;
    assign bus.resp_err   = err_q;
    assign busy           = (state != IDLE);

endmodule
